// File: rtl/lc4_cmp_pkg.sv
// Shared definitions for the lc4_cmp_iter comparator: mode and state
// encodings plus width-scaled result constants (+1 / 0 / -1).
package lc4_cmp_pkg;

  typedef enum logic [1:0] {
    MODE_CMP   = 2'b00,
    MODE_CMPU  = 2'b01,
    MODE_CMPI  = 2'b10,
    MODE_CMPIU = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Widest result the constant helpers can describe; callers size down.
  localparam int unsigned RES_MAX_W = 64;

  // Truncate a result pattern to the low 'width' bits.
  function automatic logic [RES_MAX_W-1:0] res_fit(input int unsigned width,
                                                   input logic [RES_MAX_W-1:0] value);
    logic [RES_MAX_W-1:0] mask;
    mask = (width >= RES_MAX_W) ? '1 : ((RES_MAX_W'(1) << width) - RES_MAX_W'(1));
    return value & mask;
  endfunction

  function automatic logic [RES_MAX_W-1:0] res_gt(input int unsigned width);
    return res_fit(width, RES_MAX_W'(1));
  endfunction

  function automatic logic [RES_MAX_W-1:0] res_eq(input int unsigned width);
    return res_fit(width, '0);
  endfunction

  function automatic logic [RES_MAX_W-1:0] res_lt(input int unsigned width);
    return res_fit(width, '1);
  endfunction

endpackage

// File: rtl/lc4_cmp_iter_if.sv
// Request/response bundle of the iterative comparator. The master issues
// compare requests and consumes results; the slave is the comparator.
interface lc4_cmp_iter_if
  import lc4_cmp_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  mode_e            mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, mode, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, mode, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/lc4_cmp_digit.sv
// One DIGIT-wide unsigned magnitude compare; the top feeds it the current
// most-significant digit of both operands.
module lc4_cmp_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_dig,
  input  logic [DIGIT-1:0] b_dig,
  output logic             gt,
  output logic             lt
);
  assign gt = (a_dig > b_dig);
  assign lt = (a_dig < b_dig);
endmodule

// File: rtl/lc4_cmp_iter.sv
// Iterative multi-mode comparator (CMP / CMPU / CMPI / CMPIU), DIGIT bits
// per cycle, MSB first, result +1 / 0 / -1 behind a valid/ready handshake.
// Build option LC4_CMP_EARLY_EXIT_EN: when defined, RUN stops at the first
// differing digit (variable latency); otherwise every digit is examined and
// the first difference is held in sticky flags (latency WIDTH/DIGIT).
module lc4_cmp_iter
  import lc4_cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int IMM_WIDTH  = 7,
  parameter int UIMM_WIDTH = 7
) (
  input logic           clk,
  input logic           rst_n,
  lc4_cmp_iter_if.slave bus
);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("lc4_cmp_iter: WIDTH must be a multiple of DIGIT");
  end
  if (IMM_WIDTH < 1 || IMM_WIDTH > WIDTH) begin : g_bad_imm
    $error("lc4_cmp_iter: IMM_WIDTH out of range");
  end
  if (UIMM_WIDTH < 1 || UIMM_WIDTH > WIDTH) begin : g_bad_uimm
    $error("lc4_cmp_iter: UIMM_WIDTH out of range");
  end

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);
  localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] RES_GT   = WIDTH'(res_gt(WIDTH));
  localparam logic [WIDTH-1:0] RES_EQ   = WIDTH'(res_eq(WIDTH));
  localparam logic [WIDTH-1:0] RES_LT   = WIDTH'(res_lt(WIDTH));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a, op_b, res_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] b_ext, prep_a, prep_b;
  logic             signed_mode, accept, last, finish;
  logic             dg_gt, dg_lt, hit_gt, hit_lt;

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (cnt == LAST_DIG);

  // Operand preparation at accept: immediate extension, then bias the MSB in
  // signed modes so a plain unsigned digit compare gives the signed order.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    b_ext = bus.b;
    unique case (bus.mode)
      MODE_CMPI:  b_ext = WIDTH'($signed(bus.b[IMM_WIDTH-1:0]));
      MODE_CMPIU: b_ext = WIDTH'(bus.b[UIMM_WIDTH-1:0]);
      default:    b_ext = bus.b;
    endcase
    signed_mode = (bus.mode == MODE_CMP) || (bus.mode == MODE_CMPI);
    prep_a      = signed_mode ? (bus.a ^ SIGN_BIT) : bus.a;
    prep_b      = signed_mode ? (b_ext ^ SIGN_BIT) : b_ext;
  end

  lc4_cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .a_dig (op_a[WIDTH-1 -: DIGIT]),
    .b_dig (op_b[WIDTH-1 -: DIGIT]),
    .gt    (dg_gt),
    .lt    (dg_lt)
  );

`ifdef LC4_CMP_EARLY_EXIT_EN
  // Stop as soon as a digit differs, or after the last digit.
  assign hit_gt = dg_gt;
  assign hit_lt = dg_lt;
  assign finish = dg_gt || dg_lt || last;
`else
  logic gt_s, lt_s;

  // The first difference wins; later digits cannot override it.
  assign hit_gt = gt_s || (dg_gt && !lt_s);
  assign hit_lt = lt_s || (dg_lt && !gt_s);
  assign finish = last;

  // Sticky first-difference flags, cleared on every new request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gt_s <= 1'b0;
      lt_s <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      gt_s <= 1'b0;
      lt_s <= 1'b0;
    end else if (state_q == ST_RUN) begin
      gt_s <= hit_gt;
      lt_s <= hit_lt;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)        state_d = ST_RUN;
      ST_RUN:  if (finish)        state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    bus.in_ready  = rst_n && (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
    bus.busy      = (state_q != ST_IDLE);
  end

  assign bus.result = res_q;

  // Operand shift registers, digit counter and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_a <= prep_a;
            op_b <= prep_b;
            cnt  <= '0;
          end
        end
        ST_RUN: begin
          op_a <= op_a << DIGIT;
          op_b <= op_b << DIGIT;
          cnt  <= cnt + CNT_W'(1);
          if (finish) res_q <= hit_gt ? RES_GT : (hit_lt ? RES_LT : RES_EQ);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc4_cmp_iter.sv
// Scoreboard bench for lc4_cmp_iter (WIDTH=16, DIGIT=4, IMM/UIMM=7).
// The driver pushes the expected result and latency at each accept; a
// negedge monitor pops and compares whenever out_valid rises.
module tb_lc4_cmp_iter;
  import lc4_cmp_pkg::*;

  localparam int W    = 16;
  localparam int NDIG = 4;
`ifdef LC4_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lc4_cmp_iter_if #(.WIDTH(W)) dut_if ();

  lc4_cmp_iter #(
    .WIDTH(W), .DIGIT(4), .IMM_WIDTH(7), .UIMM_WIDTH(7)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if.slave)
  );

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           acc_cyc;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: one comparison set per result presented.
  always @(negedge clk) begin
    if (dut_if.out_valid && !prev_ov) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %h with no request outstanding", dut_if.result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_result"}, 32'(dut_if.result), 32'(e.res));
        check({e.name, "_latency"}, 32'(cyc - e.acc_cyc), 32'(e.lat));
      end
    end
    prev_ov = dut_if.out_valid;
  end

  task automatic issue(input string name, input mode_e m, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] er, input int lat_early);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    dut_if.in_valid = 1'b1;
    dut_if.mode     = m;
    dut_if.a        = av;
    dut_if.b        = bv;
    while (!dut_if.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: in_ready stayed 0 for %0d cycles, required 1", name, n);
      dut_if.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    dut_if.in_valid = 1'b0;
    e.res     = er;
    e.lat     = EARLY ? lat_early : NDIG;
    e.acc_cyc = cyc;
    e.name    = name;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s_result_timeout: %0d results outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    dut_if.in_valid  = 1'b0;
    dut_if.mode      = MODE_CMP;
    dut_if.a         = '0;
    dut_if.b         = '0;
    dut_if.out_ready = 1'b1;
    rst_n            = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(dut_if.out_valid), 32'(0));
    check("reset_result",    32'(dut_if.result),    32'(0));
    check("reset_in_ready",  32'(dut_if.in_ready),  32'(0));
    check("reset_busy",      32'(dut_if.busy),      32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(dut_if.in_ready), 32'(1));

    // Signed -1 vs +1.
    issue("cmp_m1_vs_p1", MODE_CMP, 16'hFFFF, 16'h0001, 16'hFFFF, 1);
    drain("cmp_m1_vs_p1");

    // Unsigned 0xFFFF vs 1 under backpressure.
    dut_if.out_ready = 1'b0;
    issue("cmpu_ffff_vs_1", MODE_CMPU, 16'hFFFF, 16'h0001, 16'h0001, 1);
    n = 0;
    while (!dut_if.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_reached_done", 32'(dut_if.out_valid), 32'(1));
    for (int i = 0; i < 5; i++) begin
      check("bp_result",    32'(dut_if.result),    32'h0001);
      check("bp_out_valid", 32'(dut_if.out_valid), 32'(1));
      check("bp_in_ready",  32'(dut_if.in_ready),  32'(0));
      if (i == 1) begin
        dut_if.in_valid = 1'b1;
        dut_if.mode     = MODE_CMPU;
        dut_if.a        = 16'h0000;
        dut_if.b        = 16'hFFFF;
      end
      if (i == 2) dut_if.in_valid = 1'b0;
      @(negedge clk);
    end
    dut_if.out_ready = 1'b1;
    check("hs_in_ready", 32'(dut_if.in_ready), 32'(0));
    @(negedge clk);
    check("post_hs_out_valid", 32'(dut_if.out_valid), 32'(0));
    check("post_hs_in_ready",  32'(dut_if.in_ready),  32'(1));
    check("post_hs_busy",      32'(dut_if.busy),      32'(0));
    check("post_hs_result",    32'(dut_if.result),    32'h0001);
    check("post_hs_pending",   32'(exp_q.size()),     32'(0));

    // Assorted directed vectors.
    issue("cmp_min_vs_max",  MODE_CMP,   16'h8000, 16'h7FFF, 16'hFFFF, 1);
    issue("cmp_gt_digit3",   MODE_CMP,   16'h0123, 16'h0113, 16'h0001, 3);
    issue("cmp_equal_min",   MODE_CMP,   16'h8000, 16'h8000, 16'h0000, 4);
    issue("cmpu_lt_digit4",  MODE_CMPU,  16'h1234, 16'h1235, 16'hFFFF, 4);
    issue("cmpi_5_vs_m1",    MODE_CMPI,  16'h0005, 16'h007F, 16'h0001, 1);
    issue("cmpi_pos_imm_eq", MODE_CMPI,  16'h003F, 16'hFF3F, 16'h0000, 4);
    issue("cmpi_m64_eq",     MODE_CMPI,  16'hFFC0, 16'h0040, 16'h0000, 4);
    issue("cmpiu_uimm_7f",   MODE_CMPIU, 16'h0040, 16'hFF7F, 16'hFFFF, 3);
    drain("vectors");

    // Reset on the 2nd RUN edge abandons the operation.
    issue("cmpi_abandoned", MODE_CMPI, 16'hFFC0, 16'h0040, 16'h0000, 4);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_out_valid", 32'(dut_if.out_valid), 32'(0));
    check("rst_result",    32'(dut_if.result),    32'(0));
    check("rst_in_ready",  32'(dut_if.in_ready),  32'(0));
    check("rst_busy",      32'(dut_if.busy),      32'(0));
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", 32'(dut_if.in_ready), 32'(1));
    repeat (6) @(negedge clk);
    check("rst_no_stale_valid", 32'(dut_if.out_valid), 32'(0));
    check("rst_idle_result",    32'(dut_if.result),    32'(0));

    // Recovery after reset.
    issue("cmpu_after_reset", MODE_CMPU, 16'h0000, 16'h8000, 16'hFFFF, 1);
    drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc4_cmp_iter.md
Name: lc4_cmp_iter

Overview:
- Iterative multi-mode comparator for LC4-family datapaths: the parametrised, handshaked successor to the single-cycle combinational comparator.
- Compares DIGIT bits per cycle, MSB-first, and terminates early on the first differing digit.
- Returns +1 / 0 / -1 in WIDTH-bit two's complement.
- Sits beside the ALU as a multi-cycle functional unit behind a valid/ready interface, used by width-scaled cores where a WIDTH-bit flat compare misses timing.

Parameters:
- WIDTH, 16: operand and result width.
- DIGIT, 4: bits compared per cycle; WIDTH % DIGIT == 0 is required (elaboration error otherwise).
- IMM_WIDTH, 7: signed-immediate width for CMPI; 1 <= IMM_WIDTH <= WIDTH.
- UIMM_WIDTH, 7: unsigned-immediate width for CMPIU; 1 <= UIMM_WIDTH <= WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- mode  in  2  00 CMP (signed), 01 CMPU (unsigned), 10 CMPI (signed imm), 11 CMPIU (unsigned imm).
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand; only the low IMM/UIMM bits are used in immediate modes.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  compare result.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low at an edge): state IDLE, out_valid=0, result=0, internal registers cleared. in_ready=0 while rst_n is low. Reset mid-RUN or mid-DONE abandons the operation; no result is produced.
- States:
  - IDLE: in_ready = 1. On in_valid && in_ready, latch prepared operands and go to RUN.
  - RUN: each edge examines the next digit, MSB first.
  - DONE: out_valid = 1. Go to IDLE on out_ready.
- Operand prep at accept:
  - CMPI: B' = sign-extend(b[IMM_WIDTH-1:0]).
  - CMPIU: B' = zero-extend(b[UIMM_WIDTH-1:0]).
  - CMP/CMPU: B' = b.
  - Signed modes (CMP, CMPI): invert the MSB of both a and B', then compare unsigned (bias trick).
- RUN: at each edge compare the current top digits.
  - A digit > B digit: result = 1, go to DONE.
  - A digit < B digit: result = all-ones (-1), go to DONE.
  - Digits equal: shift both operands left by DIGIT. After WIDTH/DIGIT equal digits, result = 0 and go to DONE.
- Latency: k edges after the accept edge, where k is the index (1-based) of the first differing digit, or WIDTH/DIGIT if the operands are equal. Minimum 1, maximum WIDTH/DIGIT.
- DONE: result and out_valid are held stable while out_ready is low. The unit is not re-accepted in the same cycle as out_valid && out_ready; in_ready rises on the following cycle, giving a one-cycle bubble.
- result changes only on the transition into DONE. When out_valid is low, result is the last value (0 after reset).
- in_valid while not IDLE is ignored. No X-propagation from operands outside the accept edge.

Optional Feature:
- Macro: LC4_CMP_EARLY_EXIT_EN.
- Defined: early termination as described in Behaviour; variable latency.
- Undefined: RUN always examines all WIDTH/DIGIT digits. The first difference found is kept in a sticky gt/lt flag; later digits are ignored. Constant latency = WIDTH/DIGIT. Result values are identical in both builds.

Decomposition:
- Package lc4_cmp_pkg:
  - mode encoding constants: MODE_CMP, MODE_CMPU, MODE_CMPI, MODE_CMPIU;
  - state encoding: ST_IDLE, ST_RUN, ST_DONE;
  - result constant functions: res_gt / res_eq / res_lt for a given WIDTH.
- One sub-module, lc4_cmp_digit: combinational DIGIT-wide unsigned compare producing gt and lt. Instantiated once for the top digits.

Test Plan (WIDTH=16, DIGIT=4, IMM/UIMM=7, early exit on):
1. CMP, a=16'hFFFF, b=16'h0001 -> result 16'hFFFF; out_valid 1 edge after accept.
2. CMPU, a=16'hFFFF, b=16'h0001 -> result 16'h0001; latency 1.
3. CMPI, a=16'hFFC0, b=16'h0040 (imm = -64) -> result 16'h0000; latency 4.
4. CMPIU, a=16'h0040, b=16'hFF7F (uimm=0x7F) -> result 16'hFFFF; latency 3 with the macro, 4 without.
5. Backpressure: after case 2, hold out_ready=0 for 5 cycles -> result stays 16'h0001, out_valid=1, in_ready=0. Then out_ready=1 for one edge -> out_valid=0, in_ready=1 on the next cycle. An in_valid pulse during DONE is not accepted.
6. Reset: assert rst_n=0 on the 2nd RUN edge of case 3 -> out_valid=0, result=0, in_ready=0 during reset; in_ready=1 on the first cycle after release; no stale result appears.
